// File: rtl/div_seq.sv
// div_seq: iterative restoring radix-2 divider for DIV/DIVU/REM/REMU.
// Accepts one request at a time, back-pressures issue while busy, and
// returns the quotient or remainder through a valid/ready handshake.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       div_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t            state;
  logic              sel_quo;
  logic              is_signed;
  logic              q_neg;
  logic              r_neg;
  logic [WIDTH-1:0]  dvd;
  logic [WIDTH-1:0]  dvs;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic [CW-1:0]     cnt;

  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  q_fin;
  logic [WIDTH-1:0]  r_fin;
  logic              div_by_zero;
  logic              overflow;

  // The rem bit of div_op is implied: anything that is not a divide
  // returns the remainder, so only the div and signed bits are stored.
  logic unused_rem_bit;
  assign unused_rem_bit = div_op[1];

  // Magnitude of a two's-complement value; the most negative value maps
  // to 2^(WIDTH-1), which is exactly right when read back as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] m;
    m = (v < 0) ? -v : v;
    return $unsigned(m);
  endfunction

  // Two's-complement negation applied when a recorded sign is negative.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return neg ? $unsigned(-s) : v;
  endfunction

  // Trial subtraction, sign correction and special-case detection.
  always_comb begin
    shifted     = {rem, quo[WIDTH-1]};
    diff        = shifted - {1'b0, dvs};
    q_fin       = neg_if(quo, q_neg);
    r_fin       = neg_if(rem, r_neg);
    div_by_zero = (dvs == '0);
    overflow    = is_signed && (dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs == '1);
  end

  // Control FSM and datapath registers, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      sel_quo   <= 1'b0;
      is_signed <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sel_quo   <= div_op[2];
            is_signed <= div_op[0];
            dvd       <= src1;
            dvs       <= src2;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= PREP;
          end
        end
        PREP: begin
          q_neg <= is_signed & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
          r_neg <= is_signed & dvd[WIDTH-1];
          if (div_by_zero) begin
            result    <= sel_quo ? '1 : dvd;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (overflow) begin
            result    <= sel_quo ? dvd : '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            quo   <= is_signed ? abs_val(dvd) : dvd;
            dvs   <= is_signed ? abs_val(dvs) : dvs;
            rem   <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= ITER;
          end
        end
        ITER: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          result    <= sel_quo ? q_fin : r_fin;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
